// File: rtl/instr_fetch.sv
// Multicycle instruction fetch stage: reads one instruction per request, latches it
// into the instruction register, pre-decodes the immediate type and maintains the PC.
module instr_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        fetch_start_i,
  input  logic        pc_load_i,
  input  logic [63:0] pc_next_i,
  output logic        mem_req_o,
  output logic [63:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] ir_o,
  output logic [3:0]  imm_sel_o,
  output logic        illegal_o,
  output logic        instr_valid_o,
  output logic [63:0] pc_o,
  output logic        busy_o
);

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;
  localparam int unsigned SELW = 4;
  localparam logic [ILEN-1:0] NOP = ILEN'(32'h0000_0013);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [ILEN-1:0]   ir_q, ir_d;
  logic [SELW-1:0]   imm_sel_q, imm_sel_d;
  logic              illegal_q, illegal_d;
  logic              pend_vld_q, pend_vld_d;
  logic [XLEN-1:0]   pend_pc_q, pend_pc_d;

  logic [XLEN-1:0]   redirect_tgt;
  logic [SELW-1:0]   dec_sel;
  logic              dec_ill;

  assign redirect_tgt = pc_next_i & ~XLEN'(3);

  // Opcode pre-decode of the word arriving from memory
  always_comb begin
    dec_sel = SELW'(0);
    dec_ill = 1'b0;
    case (mem_rdata_i[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: dec_sel = SELW'(1);
      7'b1100011:                         dec_sel = SELW'(2);
      7'b0110111, 7'b0010111:             dec_sel = SELW'(3);
      7'b0100011:                         dec_sel = SELW'(4);
      7'b1101111:                         dec_sel = SELW'(5);
      7'b0110011, 7'b0111011:             dec_sel = SELW'(0);
      default:                            dec_ill = 1'b1;
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    imm_sel_d  = imm_sel_q;
    illegal_d  = illegal_q;
    pend_vld_d = pend_vld_q;
    pend_pc_d  = pend_pc_q;
    case (state_q)
      IDLE: begin
        if (pc_load_i) pc_d = redirect_tgt;
        if (fetch_start_i) state_d = REQ;
      end
      REQ: begin
        if (pc_load_i) begin
          pend_vld_d = 1'b1;
          pend_pc_d  = redirect_tgt;
        end
        if (mem_ack_i) begin
          state_d    = DONE;
          ir_d       = mem_rdata_i;
          imm_sel_d  = dec_sel;
          illegal_d  = dec_ill;
          pend_vld_d = 1'b0;
          // A redirect arriving with the ack is the most recent one, so it wins
          if (pc_load_i)       pc_d = redirect_tgt;
          else if (pend_vld_q) pc_d = pend_pc_q;
          else                 pc_d = pc_q + XLEN'(4);
        end
      end
      DONE: begin
        if (pc_load_i) pc_d = redirect_tgt;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= NOP;
      imm_sel_q  <= SELW'(1);
      illegal_q  <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      imm_sel_q  <= imm_sel_d;
      illegal_q  <= illegal_d;
      pend_vld_q <= pend_vld_d;
      pend_pc_q  <= pend_pc_d;
    end
  end

  assign mem_req_o     = (state_q == REQ);
  assign mem_addr_o    = pc_q;
  assign busy_o        = (state_q != IDLE);
  assign instr_valid_o = (state_q == DONE);
  assign ir_o          = ir_q;
  assign imm_sel_o     = imm_sel_q;
  assign illegal_o     = illegal_q;
  assign pc_o          = pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed plus randomized bench for instr_fetch, checked every cycle against a
// transaction-level model of the fetch stage.
module tb_instr_fetch;

  localparam logic [63:0] RST_PC = 64'h1000;

  logic        clk = 1'b0;
  logic        reset, fetch_start, pc_load, mem_ack;
  logic [63:0] pc_next;
  logic [31:0] mem_rdata;
  logic        mem_req, illegal, instr_valid, busy;
  logic [63:0] mem_addr, pc;
  logic [31:0] ir;
  logic [3:0]  imm_sel;

  int n_assert = 0;
  int n_fail   = 0;

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .clk_i(clk), .reset_i(reset), .fetch_start_i(fetch_start),
    .pc_load_i(pc_load), .pc_next_i(pc_next),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
    .ir_o(ir), .imm_sel_o(imm_sel), .illegal_o(illegal),
    .instr_valid_o(instr_valid), .pc_o(pc), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Reference model: "waiting" means a request is outstanding, "done" means the
  // instruction was delivered on the last edge.
  bit          m_waiting, m_done, m_pend;
  logic [63:0] m_pc, m_pend_pc;
  logic [31:0] m_ir;
  logic [3:0]  m_sel;
  logic        m_ill;

  function automatic logic [4:0] ref_decode(input logic [6:0] op);
    // returns {illegal, imm_sel}
    case (op)
      7'h13, 7'h03, 7'h67: return 5'h01;
      7'h63:               return 5'h02;
      7'h37, 7'h17:        return 5'h03;
      7'h23:               return 5'h04;
      7'h6F:               return 5'h05;
      7'h33, 7'h3B:        return 5'h00;
      default:             return 5'h10;
    endcase
  endfunction

  task automatic model_edge();
    logic [4:0] d;
    logic [63:0] tgt;
    tgt = {pc_next[63:2], 2'b00};
    if (reset) begin
      m_waiting = 0; m_done = 0; m_pend = 0;
      m_pc = RST_PC; m_ir = 32'h13; m_sel = 4'd1; m_ill = 0;
    end else if (m_waiting) begin
      if (pc_load) begin m_pend = 1; m_pend_pc = tgt; end
      if (mem_ack) begin
        d = ref_decode(mem_rdata[6:0]);
        m_ir = mem_rdata; m_sel = d[3:0]; m_ill = d[4];
        m_pc = m_pend ? m_pend_pc : m_pc + 64'd4;
        m_pend = 0; m_waiting = 0; m_done = 1;
      end
    end else begin
      if (pc_load) m_pc = tgt;
      if (m_done) m_done = 0;
      else if (fetch_start) m_waiting = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("mem_req",     64'(mem_req),     64'(m_waiting));
    chk("mem_addr",    mem_addr,         m_pc);
    chk("busy",        64'(busy),        64'(m_waiting | m_done));
    chk("instr_valid", 64'(instr_valid), 64'(m_done));
    chk("ir",          64'(ir),          64'(m_ir));
    chk("imm_sel",     64'(imm_sel),     64'(m_sel));
    chk("illegal",     64'(illegal),     64'(m_ill));
    chk("pc",          pc,               m_pc);
  endtask

  // One clock: inputs already driven are sampled, model advances, outputs checked.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    reset = 0; fetch_start = 0; pc_load = 0; mem_ack = 0;
    mem_rdata = $urandom;
  endtask

  task automatic fetch(input logic [31:0] word, input int waits, input bit fs_during);
    fetch_start = 1;
    tick();
    for (int i = 0; i < waits; i++) begin
      fetch_start = fs_during;
      tick();
    end
    mem_ack = 1; mem_rdata = word; fetch_start = fs_during;
    tick();
    fetch_start = fs_during;
    tick();
  endtask

  initial begin
    logic [31:0] w;
    reset = 1; fetch_start = 0; pc_load = 0; mem_ack = 0;
    pc_next = '0; mem_rdata = '0;

    // Reset then fetch ADDI after three wait cycles
    @(negedge clk);
    reset = 1; tick();
    reset = 1; tick();
    fetch(32'h00500093, 3, 0);
    chk("addi_pc", pc, 64'h1004);
    chk("addi_ir", 64'(ir), 64'h00500093);

    // Decode sweep
    fetch(32'h00208463, 0, 0); chk("beq_sel", 64'(imm_sel), 64'd2);
    fetch(32'h123452B7, 1, 0); chk("lui_sel", 64'(imm_sel), 64'd3);
    fetch(32'h00B13423, 0, 0); chk("sd_sel",  64'(imm_sel), 64'd4);
    fetch(32'h008000EF, 2, 0); chk("jal_sel", 64'(imm_sel), 64'd5);
    fetch(32'h002081B3, 0, 0); chk("add_sel", 64'(imm_sel), 64'd0);
    chk("add_ill", 64'(illegal), 64'd0);
    fetch(32'h0000007F, 0, 0); chk("bad_ill", 64'(illegal), 64'd1);

    // Redirect in IDLE together with fetch_start
    pc_load = 1; pc_next = 64'h2003; fetch_start = 1;
    tick();
    chk("idle_redir_addr", mem_addr, 64'h2000);
    mem_ack = 1; mem_rdata = 32'h00000013; tick();
    tick();
    chk("idle_redir_pc", pc, 64'h2004);

    // Two redirects while waiting on the memory: last one wins
    fetch_start = 1; tick();
    pc_load = 1; pc_next = 64'h3000; tick();
    pc_load = 1; pc_next = 64'h4000; tick();
    chk("req_redir_addr", mem_addr, 64'h2004);
    mem_ack = 1; mem_rdata = 32'h00000013; tick();
    chk("req_redir_pc", pc, 64'h4000);
    tick();

    // PC wrap, with fetch_start held through the whole transaction
    pc_load = 1; pc_next = '1; tick();
    fetch(32'h00000013, 2, 1);
    chk("wrap_pc", pc, 64'h0);

    // Reset mid-request, then a stale ack
    fetch_start = 1; tick();
    tick();
    reset = 1; tick();
    mem_ack = 1; mem_rdata = 32'h0000006F; tick();
    tick();
    chk("midrst_pc", pc, RST_PC);
    chk("midrst_ir", 64'(ir), 64'h13);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      fetch_start = ($urandom_range(0, 1) == 1);
      mem_ack     = ($urandom_range(0, 9) < 4);
      pc_load     = !mem_ack && ($urandom_range(0, 9) < 2);
      pc_next     = {$urandom, $urandom};
      reset       = ($urandom_range(0, 99) < 2);
      case ($urandom_range(0, 3))
        0: w = {$urandom_range(0, 32'h1FF_FFFF), 7'h13};
        1: w = {$urandom_range(0, 32'h1FF_FFFF), 7'h23};
        2: w = {$urandom_range(0, 32'h1FF_FFFF), 7'h6F};
        default: w = $urandom;
      endcase
      mem_rdata = w;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Multicycle fetch stage that sits directly upstream of the immediate sign-extension unit. On request from the control FSM it reads one 32-bit instruction from instruction memory at the current PC and latches it into the instruction register. It pre-decodes the opcode into the 4-bit immediate-type code that the sign extender consumes, and maintains the 64-bit PC, including sequential increment and branch/jump redirects.

## Interface
- RESET_PC, 64'h0, PC value loaded on reset; bits [1:0] must be zero.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_start  in  1  one-cycle request from the control FSM to fetch the next instruction; honoured only in IDLE.
- pc_load  in  1  redirect strobe; the PC takes pc_next.
- pc_next  in  64  redirect target (branch/JAL target from the ALU); bits [1:0] forced to 0 on load.
- mem_req  out  1  instruction-memory read request; held high until mem_ack.
- mem_addr  out  64  read address; equals pc while mem_req is high.
- mem_ack  in  1  memory response valid; mem_rdata is sampled in the same cycle.
- mem_rdata  in  32  instruction word.
- ir  out  32  instruction register, which feeds the sign extender's instruction input.
- imm_sel  out  4  immediate type for the sign extender: 0 none, 1 I, 2 B, 3 U, 4 S, 5 J.
- illegal  out  1  the opcode in ir is not recognised.
- instr_valid  out  1  one-cycle pulse when ir, imm_sel and illegal are updated.
- pc  out  64  address of the next instruction to fetch.
- busy  out  1  high in every state except IDLE.

## Operation
- **States and transitions.** IDLE, REQ, DONE.
  - IDLE → REQ on fetch_start.
  - REQ → DONE on mem_ack.
  - DONE → IDLE unconditionally.
- **IDLE.** mem_req = 0. pc_load sets pc <= {pc_next[63:2], 2'b00}. If pc_load and fetch_start are asserted in the same cycle, the redirect applies first and the fetch uses the new PC.
- **REQ.**
  - mem_req = 1 and mem_addr = pc, both stable until mem_ack.
  - On mem_ack: ir <= mem_rdata, imm_sel and illegal are decoded from mem_rdata[6:0], and the PC updates:
    - if a redirect is pending: pc <= the pending target, and the pending flag clears;
    - otherwise: pc <= pc + 4, wrapping modulo 2^64.
- **Redirect during REQ.** pc_load in REQ does not change mem_addr. The target is stored in a one-entry pending register; a later pc_load in REQ overwrites it (last wins).
- **DONE.** instr_valid = 1 for exactly this one cycle. pc_load here applies immediately, as in IDLE. ir, imm_sel and illegal hold until the next mem_ack.
- **fetch_start outside IDLE** is ignored. It is not queued.
- **Opcode decode** (mem_rdata[6:0] → imm_sel, illegal):
  - 0010011, 0000011, 1100111 → 1, 0
  - 1100011 → 2, 0
  - 0110111, 0010111 → 3, 0
  - 0100011 → 4, 0
  - 1101111 → 5, 0
  - 0110011, 0111011 → 0, 0
  - any other value → 0, 1
- **Reset** at any cycle, including mid-REQ:
  - the state returns to IDLE and the pending redirect clears;
  - the outstanding memory request is abandoned, so a mem_ack arriving after reset is ignored.

## Timing
- **Reset values:** pc = RESET_PC, ir = 32'h0000_0013 (NOP), imm_sel = 1, illegal = 0, instr_valid = 0, mem_req = 0, mem_addr = RESET_PC, busy = 0.
- mem_req rises in the cycle after fetch_start is sampled.
- **Minimum latency**, with mem_ack in the first REQ cycle: fetch_start at edge N → REQ from N+1 → ir updated at N+2 → instr_valid high from N+2 to N+3.
- **Throughput:** at most one instruction every 3 cycles.
- **Output timing:** mem_req, mem_addr, busy and instr_valid are decoded from the state register; ir, pc, imm_sel and illegal are registered. No combinational path runs from mem_ack to any output.
- mem_ack is ignored outside REQ.

## Test plan
- **Reset then fetch.** RESET_PC = 0x1000; reset for 2 cycles, then pulse fetch_start. Memory acks after 3 wait cycles with 0x00500093 (ADDI). Required: mem_addr = 0x1000 throughout REQ; then ir = 0x00500093, imm_sel = 1, illegal = 0, pc = 0x1004, and a single instr_valid pulse.
- **Decode sweep.** Fetch BEQ 0x00208463, LUI 0x123452B7, SD 0x00B13423, JAL 0x008000EF, ADD 0x002081B3 and opcode 0x7F in turn. Required imm_sel: 2, 3, 4, 5, 0, 0. illegal is 1 only for opcode 0x7F.
- **Redirect in IDLE.** pc_load with pc_next = 0x2003 in the same cycle as fetch_start. Required: mem_addr = 0x2000, and pc = 0x2004 after the fetch.
- **Redirect during REQ.** pc_load with 0x3000 and then 0x4000 while waiting on mem_ack. Required: mem_addr stays at the old PC, and pc = 0x4000 after mem_ack.
- **Wrap and ignore.** pc = 0xFFFF_FFFF_FFFF_FFFC; fetch completes. Required: pc = 0. A fetch_start issued during REQ causes no second request.
- **Mid-fetch reset.** Assert reset in REQ, then drive mem_ack one cycle later. Required: state IDLE, mem_req = 0, ir = 0x13, no instr_valid pulse, pc = RESET_PC.
